// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer
//   Snapshots the N*N parallel result words of the matrix-inverse core on a
//   capture pulse and streams them out one word per valid/ready handshake,
//   tagged with source row/column and a last flag. Optional transpose gives
//   column-major order.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   in_flat      N*N*W packed words, element k = row*N+col at [k*W +: W]
//   capture      one-cycle request to snapshot in_flat and start streaming
//   transpose    sampled with capture; 1 = column-major emission
//   out_data     current element
//   out_valid    out_data/out_row/out_col/out_last are valid
//   out_ready    consumer accepts when out_valid & out_ready
//   out_row      source row of out_data
//   out_col      source column of out_data
//   out_last     high with the final (N*N-th) element
//   busy         high while the stream is in progress
//   done         one-cycle pulse the cycle after the final transfer
//   capture_err  one-cycle pulse after a capture that arrived mid-stream
module matrix_result_streamer #(
  parameter int N  = 5,
  parameter int W  = 16,
  parameter int IW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N*N*W-1:0]  in_flat,
  input  logic              capture,
  input  logic              transpose,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IW-1:0]     out_row,
  output logic [IW-1:0]     out_col,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              capture_err
);

  localparam int NN = N * N;
  localparam int AW = $clog2(NN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    snap_q [NN];
  logic            tr_q;
  logic [IW-1:0]   outer_q, inner_q;
  logic            err_q;

  logic            fire;
  logic            at_end;
  logic [AW-1:0]   idx;

  assign fire   = out_valid && out_ready;
  assign at_end = (outer_q == IW'(N - 1)) && (inner_q == IW'(N - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs regardless of process order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d takes its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (capture)        state_d = STREAM;
      STREAM:  if (fire && at_end) state_d = DONE;
      DONE:                        state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Outputs. Counters sit at (0,0) outside STREAM, and out_data is gated so
  // idle cycles never expose stale snapshot contents.
  always_comb begin
    out_valid = (state_q == STREAM);
    busy      = (state_q == STREAM);
    done      = (state_q == DONE);
    out_row   = tr_q ? inner_q : outer_q;
    out_col   = tr_q ? outer_q : inner_q;
    out_last  = out_valid && at_end;
    idx       = AW'(out_row) * AW'(N) + AW'(out_col);
    out_data  = out_valid ? snap_q[idx] : '0;
  end

  assign capture_err = err_q;

  // Snapshot buffer, emission counters and error pulse.
  // NOTE: the snapshot buffer is cleared on reset so out_data is defined
  // from the first cycle; it is small enough to live in flops, not RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NN; k++) snap_q[k] <= '0;
      tr_q    <= 1'b0;
      outer_q <= '0;
      inner_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= capture && (state_q == STREAM);
      if (state_q == IDLE && capture) begin
        for (int k = 0; k < NN; k++) snap_q[k] <= in_flat[k*W +: W];
        tr_q    <= transpose;
        outer_q <= '0;
        inner_q <= '0;
      end else if (state_q == STREAM && fire) begin
        if (inner_q == IW'(N - 1)) begin
          inner_q <= '0;
          // Wrap outer on the last element so IDLE always shows (0,0).
          outer_q <= at_end ? '0 : outer_q + 1'b1;
        end else begin
          inner_q <= inner_q + 1'b1;
        end
      end
    end
  end

endmodule
